// File: rtl/gearbox_fifo.sv
// Bit-granular circular FIFO packing WR_W-bit writes into RD_W-bit reads (LSB-first), with level and hysteretic watermarks.
// Latency: a write accepted at edge N is visible on rd_valid/rd_data in cycle N+1; rd_data is first-word-fall-through.
// Backpressure: wr_ready/rd_valid come from the registered level only; a same-cycle pop or push is never credited.
module gearbox_fifo #(
    parameter int WR_W     = 16,
    parameter int RD_W     = 24,
    parameter int BUF_BITS = 512,
    parameter int HW_MARK  = 384,
    parameter int LW_MARK  = 128,
    parameter int HYST     = 16
) (
    input  logic                          clk,
    input  logic                          clear_n,
    input  logic                          flush,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [WR_W-1:0]               wr_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [RD_W-1:0]               rd_data,
    output logic [$clog2(BUF_BITS):0]     level,
    output logic                          almost_full,
    output logic                          almost_empty
);
    localparam int AW  = $clog2(BUF_BITS);
    localparam int PW  = AW + 1;
    localparam int WIX = (WR_W > 1) ? $clog2(WR_W) : 1;

    localparam logic [PW-1:0] HW_SET = PW'(HW_MARK);
    localparam logic [PW-1:0] HW_CLR = PW'(HW_MARK - HYST);
    localparam logic [PW-1:0] LW_SET = PW'(LW_MARK);
    localparam logic [PW-1:0] LW_CLR = PW'(LW_MARK + HYST);

    logic [BUF_BITS-1:0] mem;
    logic [BUF_BITS-1:0] wr_hit;
    logic [BUF_BITS-1:0] wr_bit;
    logic [PW-1:0]       wr_ptr, rd_ptr, level_q;
    logic [PW-1:0]       wr_ptr_n, rd_ptr_n, level_n;
    logic                af_q, ae_q, af_n, ae_n;
    logic                wr_acc, rd_acc;
    logic [AW-1:0]       wr_addr, rd_addr;

    assign wr_ready = (PW'(BUF_BITS) - level_q) >= PW'(WR_W);
    assign rd_valid = level_q >= PW'(RD_W);
    assign wr_acc   = wr_valid && wr_ready;
    assign rd_acc   = rd_valid && rd_ready;
    assign wr_addr  = wr_ptr[AW-1:0];
    assign rd_addr  = rd_ptr[AW-1:0];

    // Each storage bit works out its distance from the write head; modulo
    // arithmetic on AW bits makes a word straddling the top wrap naturally.
    for (genvar b = 0; b < BUF_BITS; b++) begin : g_wr
        logic [AW-1:0] off;
        assign off       = AW'(b) - wr_addr;
        assign wr_hit[b] = wr_acc && (off < AW'(WR_W));
        assign wr_bit[b] = wr_data[off[WIX-1:0]];
    end

    for (genvar i = 0; i < RD_W; i++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra         = rd_addr + AW'(i);
        assign rd_data[i] = mem[ra];
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < BUF_BITS; b++) begin
            if (wr_hit[b]) begin
                mem[b] <= wr_bit[b];
            end
        end
    end

    always_comb begin
        wr_ptr_n = wr_ptr + (wr_acc ? PW'(WR_W) : '0);
        rd_ptr_n = rd_ptr + (rd_acc ? PW'(RD_W) : '0);
        level_n  = wr_ptr_n - rd_ptr_n;
        af_n     = af_q;
        ae_n     = ae_q;
        if (level_n > HW_SET) begin
            af_n = 1'b1;
        end else if (level_n <= HW_CLR) begin
            af_n = 1'b0;
        end
        if (level_n <= LW_SET) begin
            ae_n = 1'b1;
        end else if (level_n > LW_CLR) begin
            ae_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            level_q <= level_n;
            af_q    <= af_n;
            ae_q    <= ae_n;
        end
    end

    assign level        = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
endmodule
